mem_stage_controller: RTL and testbench
=======================================

Name: mem_stage_controller

Overview:
Sequences the data-memory access for the instruction held in the EX/MEM pipeline register.
- Launches one bus transaction per valid load or store, using a req/ack handshake.
- Holds the pipeline through o_stall until the access completes.
- Aligns and extends load data, and generates byte-lane strobes for stores.
- Sits between the EX/MEM register outputs and the data-bus master port; its o_stall feeds the stall inputs of all upstream pipeline registers.

Parameters:
TIMEOUT, 255, bus cycles allowed in REQ before abort (only with MEMCTL_TIMEOUT_EN); counter width $clog2(TIMEOUT+1)
DATA_WIDTH, 32, width of Data and bus data; address width equals DATA_WIDTH

Ports:
i_clock  in  1  clock; all state changes on the rising edge
i_reset  in  1  synchronous, active-high reset
i_isValid  in  1  EX/MEM holds a valid instruction
i_dataR  in  32  effective address (ALU result)
i_dataB  in  32  store data
i_memWrEnable  in  1  instruction is a store
i_memRdEnable  in  1  instruction is a load
i_memAccess  in  2  DataAccess: 00 byte, 01 half, 10 word
i_memUnsigned  in  1  load is zero-extended
i_extStall  in  1  a downstream stage requests a hold
o_stall  out  1  hold IF/ID, ID/EX and EX/MEM
o_busReq  out  1  bus request, registered
o_busWr  out  1  1 = write, 0 = read; valid while o_busReq
o_busAddr  out  32  word-aligned address ({addr[31:2],2'b00})
o_busWrData  out  32  store data replicated into the byte lanes
o_busByteEn  out  4  active byte lanes
i_busAck  in  1  transaction complete; read data is valid in the same cycle
i_busRdData  in  32  read data
o_rdData  out  32  aligned and extended load result for WB
o_rdValid  out  1  o_rdData is valid (high in DONE when the access was a load)
o_misaligned  out  1  single-cycle pulse: misaligned access was suppressed
o_busFault  out  1  single-cycle pulse: timeout abort

Behaviour:
- States: IDLE, REQ, DONE. Reset values: state IDLE; all registered outputs 0; counter 0.
- memOp = i_isValid & (i_memRdEnable | i_memWrEnable).
- misaligned = (half & addr[0]) | (word & addr[1:0] != 0).
- IDLE:
  - memOp & !misaligned: o_stall = 1 (combinational), latch bus fields, go to REQ.
  - memOp & misaligned: pulse o_misaligned next cycle, no bus access, no stall, stay in IDLE.
- REQ:
  - o_busReq = 1; o_stall = 1; bus fields are held stable.
  - On i_busAck: capture the extended i_busRdData into o_rdData (loads only), drop o_busReq, go to DONE.
- DONE:
  - o_stall = i_extStall; o_rdValid = 1 for loads.
  - If !i_extStall, go to IDLE; EX/MEM advances on this edge.
  - If i_extStall, remain in DONE.
- Minimum latency with zero-wait ack: detect, REQ+ack, DONE, i.e. 2 stall cycles per memory instruction. Back-to-back memory operations add no extra bubble beyond these.
- Load extension: select the lane by addr[1:0] (byte) or addr[1] (half); sign-extend unless i_memUnsigned; word loads pass through.
- Store strobes:
  - byte: 0001 << addr[1:0], data replicated x4
  - half: 0011 << {addr[1],1'b0}, data replicated x2
  - word: 1111
- i_extStall while in IDLE: no new launch until it clears.
- Reset in REQ: o_busReq drops on the same edge; the bus tolerates an abandoned request.
- Reset has priority over every other event.
- i_busAck outside REQ is ignored.

Optional Feature:
MEMCTL_TIMEOUT_EN
- Defined: the counter clears on entry to REQ and increments each REQ cycle without ack. On reaching TIMEOUT, drop o_busReq, pulse o_busFault, set o_rdData = 0, go to DONE.
- An ack arriving on the same cycle as the timeout wins.
- Undefined: no counter, REQ waits indefinitely, o_busFault tied 0.

Decomposition:
- Types package:
  - DataAccess enum (existing)
  - MemCtlState enum {IDLE, REQ, DONE}
  - ByteEn typedef (logic [3:0])
- Sub-module mem_lane_align: combinational store lane/strobe generation and load extraction/extension; instantiated once.

Test Plan:
1. LW addr 0x100, ack on the 1st REQ cycle, rdData 0xDEADBEEF -> o_busAddr 0x100, byteEn 1111, o_stall high exactly 2 cycles, o_rdData 0xDEADBEEF with o_rdValid in DONE.
2. LB signed, addr 0x203, bus data 0x80FF_FFFF -> byteEn 1000, o_rdData 0xFFFFFF80. Same access as LBU -> 0x00000080.
3. SH addr 0x302, data 0x0000ABCD -> o_busWr 1, byteEn 1100, o_busWrData 0xABCDABCD. Ack delayed 5 cycles -> o_stall high 6 cycles and bus fields stable throughout.
4. LW addr 0x101 -> o_misaligned pulse, o_busReq never asserted, o_stall stays 0.
5. Reset asserted in the 3rd REQ cycle -> next cycle state IDLE, o_busReq 0, o_stall 0. A later ack is ignored.
6. MEMCTL_TIMEOUT_EN with TIMEOUT=4, no ack -> o_busReq high 4 cycles, then an o_busFault pulse, o_rdData 0, pipeline released.

Source files
------------

// File: rtl/mem_stage_controller_pkg.sv
// Shared types for the data-memory stage controller.
// Access sizes, controller state encoding, byte-lane strobe type, alignment check.
package mem_stage_controller_pkg;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'b00,
        ACC_HALF = 2'b01,
        ACC_WORD = 2'b10
    } DataAccess;

    typedef enum logic [1:0] {
        MCS_IDLE = 2'b00,
        MCS_REQ  = 2'b01,
        MCS_DONE = 2'b10
    } MemCtlState;

    typedef logic [3:0] ByteEn;

    // The unused encoding 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input DataAccess acc,
                                           input logic [1:0] lo);
        logic r;
        case (acc)
            ACC_BYTE: r = 1'b0;
            ACC_HALF: r = lo[0];
            default:  r = |lo;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_stage_controller_lane_align.sv
// mem_lane_align: store lane replication / strobes and load extraction / extension.
// Ports: i_access, i_addrLo, i_unsigned, i_storeData, i_busRdData -> o_busWrData, o_byteEn, o_loadData.
module mem_lane_align
    import mem_stage_controller_pkg::*;
(
    input  DataAccess   i_access,
    input  logic [1:0]  i_addrLo,
    input  logic        i_unsigned,
    input  logic [31:0] i_storeData,
    input  logic [31:0] i_busRdData,
    output logic [31:0] o_busWrData,
    output ByteEn       o_byteEn,
    output logic [31:0] o_loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        o_busWrData = i_storeData;
        o_byteEn    = 4'b1111;
        o_loadData  = i_busRdData;
        case (i_access)
            ACC_BYTE: begin
                o_busWrData = {4{i_storeData[7:0]}};
                o_byteEn    = 4'b0001 << i_addrLo;
                w_byte      = 8'(i_busRdData >> {i_addrLo, 3'b000});
                o_loadData  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            end
            ACC_HALF: begin
                o_busWrData = {2{i_storeData[15:0]}};
                o_byteEn    = 4'b0011 << {i_addrLo[1], 1'b0};
                w_half      = 16'(i_busRdData >> {i_addrLo[1], 4'b0000});
                o_loadData  = {{16{~i_unsigned & w_half[15]}}, w_half};
            end
            default: begin
                o_busWrData = i_storeData;
                o_byteEn    = 4'b1111;
                o_loadData  = i_busRdData;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_controller.sv
// Sequences one req/ack data-bus transaction per valid load/store in EX/MEM and
// stalls the pipeline until it completes; aligns load data, builds store strobes.
// Ports: i_clock, i_reset (sync, active high); EX/MEM fields i_isValid, i_dataR,
// i_dataB, i_memWrEnable, i_memRdEnable, i_memAccess, i_memUnsigned, i_extStall;
// bus o_busReq/o_busWr/o_busAddr/o_busWrData/o_busByteEn, i_busAck/i_busRdData;
// results o_stall, o_rdData, o_rdValid, o_misaligned, o_busFault.
// Optional macro MEMCTL_TIMEOUT_EN: abort a request after TIMEOUT cycles.
module mem_stage_controller
    import mem_stage_controller_pkg::*;
#(
    parameter int TIMEOUT    = 255,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_isValid,
    input  logic [DATA_WIDTH-1:0] i_dataR,
    input  logic [DATA_WIDTH-1:0] i_dataB,
    input  logic                  i_memWrEnable,
    input  logic                  i_memRdEnable,
    input  logic [1:0]            i_memAccess,
    input  logic                  i_memUnsigned,
    input  logic                  i_extStall,
    output logic                  o_stall,
    output logic                  o_busReq,
    output logic                  o_busWr,
    output logic [DATA_WIDTH-1:0] o_busAddr,
    output logic [DATA_WIDTH-1:0] o_busWrData,
    output logic [3:0]            o_busByteEn,
    input  logic                  i_busAck,
    input  logic [DATA_WIDTH-1:0] i_busRdData,
    output logic [DATA_WIDTH-1:0] o_rdData,
    output logic                  o_rdValid,
    output logic                  o_misaligned,
    output logic                  o_busFault
);

    localparam logic [1:0] S_IDLE = MCS_IDLE;
    localparam logic [1:0] S_REQ  = MCS_REQ;
    localparam logic [1:0] S_DONE = MCS_DONE;

    // A zero timeout would abort before the bus could ever answer.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    logic [1:0]            r_state;
    logic                  r_busReq;
    logic                  r_busWr;
    logic [DATA_WIDTH-1:0] r_busAddr;
    logic [DATA_WIDTH-1:0] r_busWrData;
    ByteEn                 r_busByteEn;
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_rdValid;
    logic                  r_misaligned;
    logic                  r_busFault;
    logic                  r_isLoad;

    logic                  w_memOp;
    logic                  w_misaligned;
    logic                  w_launch;
    logic                  w_ack;
    logic                  w_abort;
    logic                  w_stall;
    logic [DATA_WIDTH-1:0] w_alignWrData;
    ByteEn                 w_alignByteEn;
    logic [DATA_WIDTH-1:0] w_alignLoad;

    assign w_memOp      = i_isValid & (i_memRdEnable | i_memWrEnable);
    assign w_misaligned = is_misaligned(DataAccess'(i_memAccess), i_dataR[1:0]);
    assign w_launch     = (r_state == S_IDLE) & w_memOp & ~w_misaligned
                        & ~i_extStall;
    assign w_ack        = (r_state == S_REQ) & i_busAck;

    // EX/MEM is frozen while we stall, so the live fields stay valid at ack.
    mem_lane_align u_align (
        .i_access    (DataAccess'(i_memAccess)),
        .i_addrLo    (i_dataR[1:0]),
        .i_unsigned  (i_memUnsigned),
        .i_storeData (i_dataB),
        .i_busRdData (i_busRdData),
        .o_busWrData (w_alignWrData),
        .o_byteEn    (w_alignByteEn),
        .o_loadData  (w_alignLoad)
    );

`ifdef MEMCTL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_count;

    // Fires on the TIMEOUT-th unanswered REQ cycle; a same-cycle ack wins.
    assign w_abort = (r_state == S_REQ) & ~i_busAck
                   & (r_count == CW'(TIMEOUT - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (w_launch) begin
            r_count <= '0;
        end else if ((r_state == S_REQ) & ~i_busAck) begin
            r_count <= r_count + 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = i_extStall | (w_memOp & ~w_misaligned);
            S_REQ:   w_stall = 1'b1;
            S_DONE:  w_stall = i_extStall;
            default: w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_busReq     <= 1'b0;
            r_busWr      <= 1'b0;
            r_busAddr    <= '0;
            r_busWrData  <= '0;
            r_busByteEn  <= '0;
            r_rdData     <= '0;
            r_rdValid    <= 1'b0;
            r_misaligned <= 1'b0;
            r_busFault   <= 1'b0;
            r_isLoad     <= 1'b0;
        end else begin
            r_misaligned <= (r_state == S_IDLE) & w_memOp & w_misaligned
                          & ~i_extStall;
            r_busFault   <= w_abort;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_state     <= S_REQ;
                        r_busReq    <= 1'b1;
                        r_busWr     <= i_memWrEnable;
                        r_busAddr   <= {i_dataR[DATA_WIDTH-1:2], 2'b00};
                        r_busWrData <= w_alignWrData;
                        r_busByteEn <= w_alignByteEn;
                        r_isLoad    <= ~i_memWrEnable;
                    end
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_state   <= S_DONE;
                        r_busReq  <= 1'b0;
                        r_rdValid <= r_isLoad;
                        if (r_isLoad) begin
                            r_rdData <= w_alignLoad;
                        end
                    end else if (w_abort) begin
                        r_state   <= S_DONE;
                        r_busReq  <= 1'b0;
                        r_rdValid <= r_isLoad;
                        r_rdData  <= '0;
                    end
                end
                S_DONE: begin
                    if (!i_extStall) begin
                        r_state   <= S_IDLE;
                        r_rdValid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_stall      = w_stall;
    assign o_busReq     = r_busReq;
    assign o_busWr      = r_busWr;
    assign o_busAddr    = r_busAddr;
    assign o_busWrData  = r_busWrData;
    assign o_busByteEn  = r_busByteEn;
    assign o_rdData     = r_rdData;
    assign o_rdValid    = r_rdValid;
    assign o_misaligned = r_misaligned;
    assign o_busFault   = r_busFault;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Self-checking bench for mem_stage_controller: directed plan cases plus
// randomized loads/stores against a behavioural model of the memory stage.
`timescale 1ns/1ps
module tb_mem_stage_controller;

`ifdef MEMCTL_TIMEOUT_EN
    localparam int TO   = 4;
    localparam int MAXD = 4;
`else
    localparam int TO   = 255;
    localparam int MAXD = 6;
`endif

    logic        clk = 1'b0;
    logic        i_reset, i_isValid, i_memWrEnable, i_memRdEnable;
    logic        i_memUnsigned, i_extStall, i_busAck;
    logic [1:0]  i_memAccess;
    logic [31:0] i_dataR, i_dataB, i_busRdData;
    logic        o_stall, o_busReq, o_busWr, o_rdValid;
    logic        o_misaligned, o_busFault;
    logic [31:0] o_busAddr, o_busWrData, o_rdData;
    logic [3:0]  o_busByteEn;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_controller #(.TIMEOUT(TO), .DATA_WIDTH(32)) dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_isValid     (i_isValid),
        .i_dataR       (i_dataR),
        .i_dataB       (i_dataB),
        .i_memWrEnable (i_memWrEnable),
        .i_memRdEnable (i_memRdEnable),
        .i_memAccess   (i_memAccess),
        .i_memUnsigned (i_memUnsigned),
        .i_extStall    (i_extStall),
        .o_stall       (o_stall),
        .o_busReq      (o_busReq),
        .o_busWr       (o_busWr),
        .o_busAddr     (o_busAddr),
        .o_busWrData   (o_busWrData),
        .o_busByteEn   (o_busByteEn),
        .i_busAck      (i_busAck),
        .i_busRdData   (i_busRdData),
        .o_rdData      (o_rdData),
        .o_rdValid     (o_rdValid),
        .o_misaligned  (o_misaligned),
        .o_busFault    (o_busFault)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_en(input int acc, input logic [31:0] a);
        int lo = int'(a % 4);
        if (acc == 0) return 32'(1 << lo);
        if (acc == 1) return 32'(3 << (lo & 2));
        return 32'hF;
    endfunction

    function automatic logic [31:0] exp_wd(input int acc, input logic [31:0] d);
        if (acc == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (acc == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_rd(input int acc, input logic [31:0] a,
                                           input bit uns, input logic [31:0] bus);
        logic [31:0] v;
        if (acc == 0) begin
            v = (bus >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (acc == 1) begin
            v = (bus >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = bus;
        end
        return v;
    endfunction

    task automatic idle();
        i_isValid     = 1'b0;
        i_memWrEnable = 1'b0;
        i_memRdEnable = 1'b0;
        i_memAccess   = 2'b10;
        i_memUnsigned = 1'b0;
        i_extStall    = 1'b0;
        i_busAck      = 1'b0;
        i_dataR       = 32'h0;
        i_dataB       = 32'h0;
    endtask

    task automatic drive(input bit wr, input int acc, input logic [31:0] addr,
                         input logic [31:0] data, input bit uns);
        i_isValid     = 1'b1;
        i_memWrEnable = wr;
        i_memRdEnable = !wr;
        i_memAccess   = 2'(acc);
        i_dataR       = addr;
        i_dataB       = data;
        i_memUnsigned = uns;
    endtask

    // One aligned access: `pre` cycles held by extStall in IDLE, ack on the
    // ackdly-th REQ cycle, `hold` extra DONE cycles held by extStall.
    task automatic run_op(input bit wr, input int acc, input logic [31:0] addr,
                          input logic [31:0] data, input bit uns,
                          input logic [31:0] bus, input int ackdly,
                          input int pre, input int hold, input string tag);
        int n_stall = 0, n_req = 0, n_bad = 0, n_val = 0;
        int n_mis = 0, n_flt = 0, last;
        bit got_req = 0;
        logic [31:0] rd_first = 32'h0, a0 = 32'h0, d0 = 32'h0;
        logic [31:0] e0 = 32'h0, w0 = 32'h0;
        logic [31:0] ea = addr & ~32'h3;
        drive(wr, acc, addr, data, uns);
        i_busRdData = bus;
        last = pre + ackdly + hold + 1;
        for (int k = 0; k <= last; k++) begin
            int j = k - pre;
            i_extStall = (j < 0) || (j > ackdly && j <= ackdly + hold);
            i_busAck   = (j == ackdly);
            @(negedge clk);
            n_stall += int'(o_stall);
            n_req   += int'(o_busReq);
            n_val   += int'(o_rdValid);
            n_mis   += int'(o_misaligned);
            n_flt   += int'(o_busFault);
            if (o_busReq) begin
                if (!got_req) begin
                    got_req = 1;
                    a0 = o_busAddr; d0 = o_busWrData;
                    e0 = 32'(o_busByteEn); w0 = 32'(o_busWr);
                end
                if (o_busAddr !== ea || 32'(o_busByteEn) !== exp_en(acc, addr)
                    || o_busWr !== wr || (wr && o_busWrData !== exp_wd(acc, data)))
                    n_bad++;
            end
            if (j == ackdly + 1) rd_first = o_rdData;
            @(posedge clk);
            #1;
        end
        i_busAck   = 1'b0;
        i_extStall = 1'b0;
        chk({tag, "_stall"}, n_stall, pre + 1 + ackdly + hold);
        chk({tag, "_reqcyc"}, n_req, ackdly);
        chk({tag, "_addr"}, a0, ea);
        chk({tag, "_byteen"}, e0, exp_en(acc, addr));
        chk({tag, "_wr"}, w0, 32'(wr));
        chk({tag, "_stable"}, n_bad, 0);
        chk({tag, "_flags"}, n_mis + n_flt, 0);
        if (wr) begin
            chk({tag, "_wrdata"}, d0, exp_wd(acc, data));
            chk({tag, "_rdvalid"}, n_val, 0);
        end else begin
            chk({tag, "_rddata"}, rd_first, exp_rd(acc, addr, uns, bus));
            chk({tag, "_rdvalid"}, n_val, hold + 1);
        end
    endtask

    task automatic run_mis(input int acc, input logic [31:0] addr,
                           input string tag);
        int n_stall = 0, n_req = 0, n_mis = 0;
        drive(1'b0, acc, addr, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_stall += int'(o_stall);
            n_req   += int'(o_busReq);
            n_mis   += int'(o_misaligned);
            @(posedge clk);
            #1;
            idle();
        end
        chk({tag, "_pulse"}, n_mis, 1);
        chk({tag, "_req"}, n_req, 0);
        chk({tag, "_stall"}, n_stall, 0);
    endtask

    task automatic run_rst();
        drive(1'b0, 2, 32'h400, 32'h0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            if (j == 3) i_reset = 1'b1;
            @(negedge clk);
            if (j == 3) chk("rst_req_before", 32'(o_busReq), 1);
            @(posedge clk);
            #1;
        end
        i_reset = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_req", 32'(o_busReq), 0);
        chk("rst_stall", 32'(o_stall), 0);
        @(posedge clk);
        #1;
        i_busAck = 1'b1;
        i_busRdData = 32'h1234_5678;
        @(posedge clk);
        #1;
        i_busAck = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(o_busReq), 0);
        chk("late_ack_valid", 32'(o_rdValid), 0);
        chk("late_ack_stall", 32'(o_stall), 0);
        chk("late_ack_rddata", o_rdData, 0);
        @(posedge clk);
        #1;
    endtask

`ifdef MEMCTL_TIMEOUT_EN
    task automatic run_timeout();
        int n_req = 0, n_flt = 0, n_stall = 0;
        logic [31:0] rd = 32'hFFFF_FFFF;
        drive(1'b0, 2, 32'h500, 32'h0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_req += int'(o_busReq);
            n_flt += int'(o_busFault);
            if (j <= 5) n_stall += int'(o_stall);
            if (j == 5) rd = o_rdData;
            @(posedge clk);
            #1;
            if (j == 5) idle();
        end
        chk("to_reqcyc", n_req, 4);
        chk("to_fault", n_flt, 1);
        chk("to_stall", n_stall, 5);
        chk("to_rddata", rd, 0);
    endtask
`endif

    initial begin
        int acc, dly, pre, hold;
        bit wr, uns;
        logic [31:0] a, d, b;
        idle();
        i_reset = 1'b1;
        i_busRdData = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busreq", 32'(o_busReq), 0);
        chk("reset_stall", 32'(o_stall), 0);
        chk("reset_rddata", o_rdData, 0);
        chk("reset_misc", {o_busByteEn, o_rdValid, o_misaligned, o_busFault, o_busWr}, 0);
        @(posedge clk);
        #1;
        i_reset = 1'b0;

        run_op(0, 2, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1, 0, 0, "lw");
        run_op(0, 0, 32'h203, 32'h0, 0, 32'h80FF_FFFF, 1, 0, 0, "lb");
        run_op(0, 0, 32'h203, 32'h0, 1, 32'h80FF_FFFF, 1, 0, 0, "lbu");
        run_op(1, 1, 32'h302, 32'h0000_ABCD, 0, 32'h0, 5, 0, 0, "sh");
        run_op(0, 1, 32'h402, 32'h0, 0, 32'h9876_0000, 2, 2, 2, "lh_ext");
        run_op(1, 0, 32'h601, 32'h0000_005A, 0, 32'h0, 1, 1, 1, "sb_ext");
        run_mis(2, 32'h101, "mis_lw");
        run_mis(1, 32'h301, "mis_lh");
`ifndef MEMCTL_TIMEOUT_EN
        run_op(0, 2, 32'h700, 32'h0, 0, 32'hCAFE_F00D, 40, 0, 0, "lw_slow");
`endif
        run_rst();
`ifdef MEMCTL_TIMEOUT_EN
        run_op(0, 2, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1, 0, 0, "lw_pre_to");
        run_timeout();
`endif

        for (int t = 0; t < 24; t++) begin
            acc  = int'($urandom_range(2, 0));
            a    = $urandom;
            d    = $urandom;
            b    = $urandom;
            wr   = 1'($urandom_range(1, 0));
            uns  = 1'($urandom_range(1, 0));
            dly  = int'($urandom_range(MAXD, 1));
            pre  = int'($urandom_range(1, 0));
            hold = int'($urandom_range(2, 0));
            if (acc == 1) a[0] = 1'b0;
            if (acc == 2) a[1:0] = 2'b00;
            if ($urandom_range(7, 0) == 0) begin
                a[0] = 1'b1;
                if (acc == 0) acc = 2;
                run_mis(acc, a, "rnd_mis");
            end else begin
                run_op(wr, acc, a, d, uns, b, dly, pre, hold, "rnd");
            end
            if ($urandom_range(1, 0) == 1) begin
                idle();
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
